// File: rtl/requantizer_if.sv
// Stream handshake bundle between the accumulator array and the activation buffer.
interface requantizer_if #(
   parameter int unsigned N          = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = DATA_WIDTH*2 + $clog2(N)
);
   logic                    in_valid;
   logic                    in_ready;
   logic [N*ACC_WIDTH-1:0]  in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [N*DATA_WIDTH-1:0] out_data;

   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data);
   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data);
endinterface

// File: rtl/requantizer.sv
// Three-stage per-lane requantizer: scale, round-half-up shift, zero-point/ReLU,
// saturation to DATA_WIDTH, with a sticky saturation-event counter.
module requantizer #(
   parameter int unsigned N           = 4,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned ACC_WIDTH   = DATA_WIDTH*2 + $clog2(N),
   parameter int unsigned SCALE_WIDTH = 16,
   parameter int unsigned SHIFT_WIDTH = 5,
   localparam int unsigned LANE_WIDTH = (N > 1) ? $clog2(N) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_lane_we,
   input  logic [LANE_WIDTH-1:0]         cfg_lane,
   input  logic signed [SCALE_WIDTH-1:0] cfg_scale,
   input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
   input  logic                          cfg_glb_we,
   input  logic signed [DATA_WIDTH-1:0]  cfg_zp,
   input  logic                          cfg_relu,
   requantizer_if.slave                  bus,
   output logic [15:0]                   sat_count,
   input  logic                          sat_clr
);
   localparam int unsigned P = ACC_WIDTH + SCALE_WIDTH;
   localparam int unsigned R = P + 1;
   localparam int unsigned T = R + 1;
   localparam logic signed [T-1:0] D_MAX = T'((1 << (DATA_WIDTH-1)) - 1);
   localparam logic signed [T-1:0] D_MIN = ~D_MAX;

   logic signed [SCALE_WIDTH-1:0] scale_q [N];
   logic [SHIFT_WIDTH-1:0]        shift_q [N];
   logic signed [DATA_WIDTH-1:0]  zp_q;
   logic                          relu_q;

   logic                          s1_valid;
   logic signed [P-1:0]           s1_prod  [N];
   logic [SHIFT_WIDTH-1:0]        s1_shift [N];
   logic signed [DATA_WIDTH-1:0]  s1_zp;
   logic                          s1_relu;

   logic                          s2_valid;
   logic signed [R-1:0]           s2_r [N];
   logic signed [DATA_WIDTH-1:0]  s2_zp;
   logic                          s2_relu;

   logic                          out_valid_q;
   logic [N*DATA_WIDTH-1:0]       out_data_q;
   logic                          out_sat_q;
   logic [15:0]                   sat_count_q;

   logic signed [P-1:0]           prod_c [N];
   logic signed [R-1:0]           rnd_c  [N];
   logic [N*DATA_WIDTH-1:0]       dat_c;
   logic [N-1:0]                  sat_c;
   logic                          en;

   // Whole pipe advances together; a held output stalls every stage.
   assign en            = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign sat_count     = sat_count_q;

   // Configuration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            scale_q[i] <= SCALE_WIDTH'(1);
            shift_q[i] <= '0;
         end
         zp_q   <= '0;
         relu_q <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (cfg_lane_we && (cfg_lane == LANE_WIDTH'(i))) begin
               scale_q[i] <= cfg_scale;
               shift_q[i] <= cfg_shift;
            end
         end
         if (cfg_glb_we) begin
            zp_q   <= cfg_zp;
            relu_q <= cfg_relu;
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_lane
      logic signed [ACC_WIDTH-1:0] acc;
      logic signed [R-1:0]         pe;
      logic signed [R-1:0]         half;
      logic signed [R-1:0]         sum;
      logic signed [T-1:0]         zx;
      logic signed [T-1:0]         t;
      logic signed [T-1:0]         tr;

      assign acc       = bus.in_data[g*ACC_WIDTH +: ACC_WIDTH];
      assign prod_c[g] = P'(acc) * P'(scale_q[g]);

      // Adding half an LSB then flooring gives round-half-up for both signs.
      assign pe       = R'(s1_prod[g]);
      assign half     = (s1_shift[g] == '0) ? '0
                        : R'(R'(1) << (s1_shift[g] - SHIFT_WIDTH'(1)));
      assign sum      = pe + half;
      assign rnd_c[g] = sum >>> s1_shift[g];

      assign zx       = T'(s2_zp);
      assign t        = T'(s2_r[g]) + zx;
      assign tr       = (s2_relu && (t < zx)) ? zx : t;
      assign sat_c[g] = (tr > D_MAX) || (tr < D_MIN);
      assign dat_c[g*DATA_WIDTH +: DATA_WIDTH] =
         (tr > D_MAX) ? D_MAX[DATA_WIDTH-1:0] :
         (tr < D_MIN) ? D_MIN[DATA_WIDTH-1:0] : tr[DATA_WIDTH-1:0];
   end

   // Pipeline stages; config travels with each beat from S1 onward
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_prod     <= '{default: '0};
         s1_shift    <= '{default: '0};
         s1_zp       <= '0;
         s1_relu     <= 1'b0;
         s2_valid    <= 1'b0;
         s2_r        <= '{default: '0};
         s2_zp       <= '0;
         s2_relu     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else if (en) begin
         s1_valid    <= bus.in_valid;
         s1_prod     <= prod_c;
         s1_shift    <= shift_q;
         s1_zp       <= zp_q;
         s1_relu     <= relu_q;
         s2_valid    <= s1_valid;
         s2_r        <= rnd_c;
         s2_zp       <= s1_zp;
         s2_relu     <= s1_relu;
         out_valid_q <= s2_valid;
         out_data_q  <= dat_c;
         out_sat_q   <= |sat_c;
      end
   end

   // Saturation event counter; clear has priority, count sticks at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count_q <= '0;
      end else if (sat_clr) begin
         sat_count_q <= '0;
      end else if (out_valid_q && bus.out_ready && out_sat_q && (sat_count_q != 16'hFFFF)) begin
         sat_count_q <= sat_count_q + 16'd1;
      end
   end
endmodule

// File: tb/tb_requantizer.sv
// Directed bench for requantizer: arithmetic reference model plus literal checks.
module tb_requantizer;
   localparam int NL = 4;
   localparam int DW = 8;
   localparam int AW = 18;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_lane_we;
   logic [1:0]        cfg_lane;
   logic [15:0]       cfg_scale;
   logic [4:0]        cfg_shift;
   logic              cfg_glb_we;
   logic [7:0]        cfg_zp;
   logic              cfg_relu;
   logic [15:0]       sat_count;
   logic              sat_clr;

   requantizer_if #(.N(NL), .DATA_WIDTH(DW)) bus ();

   requantizer #(.N(NL), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_lane_we(cfg_lane_we), .cfg_lane(cfg_lane),
      .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
      .cfg_glb_we(cfg_glb_we), .cfg_zp(cfg_zp), .cfg_relu(cfg_relu),
      .bus(bus), .sat_count(sat_count), .sat_clr(sat_clr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct { logic [NL*DW-1:0] data; bit sat; } beat_t;
   beat_t  q[$];
   longint m_scale [NL];
   int     m_shift [NL];
   longint m_zp;
   bit     m_relu;
   int     exp_sat;
   int     n_hs = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   // Reference arithmetic: exact product, floor((p + d/2) / d), offset, clamp
   function automatic void model(input longint acc, input longint sc, input int sh,
                                 input longint zp, input bit relu,
                                 output longint o, output bit sat);
      longint p, r, d, t;
      p = acc * sc;
      if (sh == 0) r = p;
      else begin
         d = longint'(1) << sh;
         r = p + d / 2;
         r = (r >= 0) ? r / d : -((-r + d - 1) / d);
      end
      t = r + zp;
      if (relu && t < zp) t = zp;
      sat = 1'b0;
      if (t > 127)       begin t = 127;  sat = 1'b1; end
      else if (t < -128) begin t = -128; sat = 1'b1; end
      o = t;
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < NL; i++) begin m_scale[i] = 1; m_shift[i] = 0; end
      m_zp = 0; m_relu = 1'b0; exp_sat = 0;
   endtask

   // Single compare process: all observation happens mid-cycle on the falling edge
   always @(negedge clk) begin
      if (!rst_n) model_reset();
      else begin
         chk("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
         chk("sat_count", 64'(sat_count), 64'(exp_sat));
         if (bus.out_valid) begin
            if (q.size() == 0) chk("out_without_beat", 64'(q.size()), 64'd1);
            else               chk("out_data", 64'(bus.out_data), 64'(q[0].data));
         end
         if (sat_clr) exp_sat = 0;
         else if (bus.out_valid && bus.out_ready && q.size() > 0 && q[0].sat && exp_sat < 65535)
            exp_sat++;
         if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            void'(q.pop_front());
            n_hs++;
         end
         if (bus.in_valid && bus.in_ready) begin
            beat_t b;
            b.sat = 1'b0;
            for (int j = 0; j < NL; j++) begin
               logic signed [AW-1:0] a;
               longint o;
               bit s;
               a = bus.in_data[j*AW +: AW];
               model(longint'(a), m_scale[j], m_shift[j], m_zp, m_relu, o, s);
               b.data[j*DW +: DW] = DW'(o);
               b.sat |= s;
            end
            q.push_back(b);
         end
         if (cfg_lane_we) begin
            m_scale[cfg_lane] = longint'($signed(cfg_scale));
            m_shift[cfg_lane] = int'(cfg_shift);
         end
         if (cfg_glb_we) begin
            m_zp   = longint'($signed(cfg_zp));
            m_relu = cfg_relu;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   function automatic logic [NL*AW-1:0] pk(input int a, input int b, input int c, input int d);
      logic [NL*AW-1:0] v;
      v[0*AW +: AW] = AW'(a);
      v[1*AW +: AW] = AW'(b);
      v[2*AW +: AW] = AW'(c);
      v[3*AW +: AW] = AW'(d);
      return v;
   endfunction

   task automatic send(input logic [NL*AW-1:0] d);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && n < 50) begin step(); n++; end
      chk("send_timeout", 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.out_valid && n < 20) begin step(); n++; end
      chk({name, "_timeout"}, 64'(bus.out_valid), 64'd1);
   endtask

   task automatic expect_out(input string name, input logic [NL*DW-1:0] want);
      wait_valid(name);
      chk(name, 64'(bus.out_data), 64'(want));
      step();
   endtask

   task automatic set_lane(input int l, input int sc, input int sh);
      cfg_lane = 2'(l); cfg_scale = 16'(sc); cfg_shift = 5'(sh); cfg_lane_we = 1'b1;
      step();
      cfg_lane_we = 1'b0;
   endtask

   task automatic set_glb(input int zp, input bit relu);
      cfg_zp = 8'(zp); cfg_relu = relu; cfg_glb_we = 1'b1;
      step();
      cfg_glb_we = 1'b0;
   endtask

   initial begin
      int sent, base;
      bit acc;
      model_reset();
      rst_n = 1'b0; cfg_lane_we = 1'b0; cfg_lane = '0; cfg_scale = '0; cfg_shift = '0;
      cfg_glb_we = 1'b0; cfg_zp = '0; cfg_relu = 1'b0; sat_clr = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
      #2;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data",  64'(bus.out_data),  64'd0);
      chk("rst_sat_count", 64'(sat_count),     64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // Defaults: pure saturating narrower, 3-cycle latency
      send(pk(300, -300, 127, -5));
      chk("lat_e1", 64'(bus.out_valid), 64'd0);
      step();
      chk("lat_e2", 64'(bus.out_valid), 64'd0);
      step();
      chk("lat_e3", 64'(bus.out_valid), 64'd1);
      chk("default_data", 64'(bus.out_data), 64'h00000000fb7f807f);
      step();
      chk("default_sat", 64'(sat_count), 64'd1);

      // Rounding
      for (int l = 0; l < NL; l++) set_lane(l, 3, 2);
      send(pk(5, -5, 6, -6));
      expect_out("round_data", 32'hfc05fc04);
      chk("round_nosat", 64'(sat_count), 64'd1);
      set_lane(0, -2, 0);
      send(pk(70, 0, 0, 0));
      expect_out("negscale_data", 32'h00000080);
      chk("negscale_sat", 64'(sat_count), 64'd2);

      // Zero-point with ReLU
      for (int l = 0; l < NL; l++) set_lane(l, 1, 0);
      set_glb(10, 1'b1);
      send(pk(-20, 0, 200, 50));
      expect_out("relu_data", 32'h3c7f0a0a);
      chk("relu_sat", 64'(sat_count), 64'd3);
      set_glb(0, 1'b0);

      // Backpressure: 6 back-to-back beats, out_ready low on cycles 4..7
      base = n_hs;
      sent = 0;
      for (int c = 0; c < 20; c++) begin
         bus.out_ready = !(c >= 4 && c <= 7);
         bus.in_valid  = (sent < 6);
         bus.in_data   = pk(sent*40 + 1, sent*40 - 29, sent*40 - 59, sent*40 - 89);
         #1;
         acc = bus.in_valid && bus.in_ready;
         step();
         if (acc) sent++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_beats_out", 64'(n_hs - base), 64'd6);

      // Counter: clear, count, clear-wins, stick at all-ones
      sat_clr = 1'b1; step(); sat_clr = 1'b0;
      chk("clr_idle", 64'(sat_count), 64'd0);
      for (int k = 0; k < 3; k++) begin
         send(pk(500, 0, 0, 0));
         expect_out("cnt_data", 32'h0000007f);
      end
      step();
      chk("cnt_three", 64'(sat_count), 64'd3);
      send(pk(-500, 0, 0, 0));
      wait_valid("clrwin");
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      chk("clr_wins", 64'(sat_count), 64'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = pk(300, 300, 300, 300);
      for (int k = 0; k < 65535; k++) step();
      bus.in_valid = 1'b0;
      repeat (5) step();
      chk("cnt_full", 64'(sat_count), 64'hFFFF);
      send(pk(300, 0, 0, 0));
      expect_out("cnt_hold_data", 32'h0000007f);
      step();
      chk("cnt_hold", 64'(sat_count), 64'hFFFF);

      // Reset mid-stream
      set_lane(1, 5, 0);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = pk(1, 2, 3, 4);
      step();
      bus.in_data  = pk(5, 6, 7, 8);
      step();
      bus.in_valid = 1'b0;
      wait_valid("rst_mid");
      chk("rst_mid_stall", 64'(bus.in_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rstm_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rstm_sat_count", 64'(sat_count),     64'd0);
      chk("rstm_in_ready",  64'(bus.in_ready),  64'd1);
      step();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rstm_no_ghost", 64'(bus.out_valid), 64'd0);
      end
      send(pk(0, 7, 0, 0));
      expect_out("rstm_identity", 32'h00000700);
      repeat (3) step();
      chk("drained", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
